// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared types for the 2D-mesh NoC router route-computation logic.
//   port_e       : output port codes (N = y-, E = x+, S = y+, W = x-, Local)
//   route_mode_e : compile-time routing algorithm selector
//   rt_state_e   : route-computation FSM states
//   port2onehot  : port code -> 5-bit one-hot vector
// ---------------------------------------------------------------------------
package noc_pkg;

   localparam int PORT_NUM = 5;

   typedef enum logic [2:0] {
      PORT_N0 = 3'd0,
      PORT_E  = 3'd1,
      PORT_S  = 3'd2,
      PORT_W  = 3'd3,
      PORT_L  = 3'd4
   } port_e;

   typedef enum logic [1:0] {
      RT_XY = 2'd0,
      RT_YX = 2'd1,
      RT_WF = 2'd2
   } route_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COMP = 2'd1,
      HOLD = 2'd2
   } rt_state_e;

   function automatic logic [PORT_NUM-1:0] port2onehot(input port_e p);
      logic [PORT_NUM-1:0] oh;
      case (p)
         PORT_N0: oh = 5'b00001;
         PORT_E:  oh = 5'b00010;
         PORT_S:  oh = 5'b00100;
         PORT_W:  oh = 5'b01000;
         PORT_L:  oh = 5'b10000;
         default: oh = 5'b00000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/rt_select.sv
// ---------------------------------------------------------------------------
// rt_select
// Combinational route selection for one header.
//   xpos, ypos : this router's coordinates
//   dstx, dsty : header destination
//   esc        : header travels on the escape VC (forces XY in adaptive mode)
//   cred       : free downstream credits, slice p belongs to port p
//   rr         : tie-break pointer (0 = x-dimension port, 1 = y-dimension)
//   port       : selected output port
//   err        : destination outside the mesh (port is Local)
//   tie        : adaptive decision was resolved by rr (caller toggles rr)
// ---------------------------------------------------------------------------
module rt_select
   import noc_pkg::*;
#(
   parameter int ARRAY_W    = 3,
   parameter int XSIZE      = 8,
   parameter int YSIZE      = 8,
   parameter int CRED_W     = 4,
   parameter int ROUTE_MODE = 0
) (
   input  logic [ARRAY_W-1:0]  xpos,
   input  logic [ARRAY_W-1:0]  ypos,
   input  logic [ARRAY_W-1:0]  dstx,
   input  logic [ARRAY_W-1:0]  dsty,
   input  logic                esc,
   input  logic [5*CRED_W-1:0] cred,
   input  logic                rr,
   output port_e               port,
   output logic                err,
   output logic                tie
);

   // One extra bit so a limit equal to 2**ARRAY_W is still representable.
   localparam logic [ARRAY_W:0] XLIM = (ARRAY_W+1)'(XSIZE);
   localparam logic [ARRAY_W:0] YLIM = (ARRAY_W+1)'(YSIZE);
   localparam route_mode_e      MODE = route_mode_e'(ROUTE_MODE[1:0]);

   logic              x_pos, x_neg, y_pos, y_neg;
   logic [CRED_W-1:0] cred_e, cred_y;
   port_e             port_y;

   assign x_pos  = dstx > xpos;
   assign x_neg  = dstx < xpos;
   assign y_pos  = dsty > ypos;
   assign y_neg  = dsty < ypos;
   assign port_y = y_pos ? PORT_S : PORT_N0;
   assign cred_e = cred[CRED_W +: CRED_W];
   assign cred_y = y_pos ? cred[2*CRED_W +: CRED_W] : cred[0 +: CRED_W];
   assign err    = ({1'b0, dstx} >= XLIM) || ({1'b0, dsty} >= YLIM);

   always_comb begin
      port = PORT_L;
      tie  = 1'b0;
      if (err) begin
         port = PORT_L;
      end else if (MODE == RT_YX) begin
         if (y_pos || y_neg) port = port_y;
         else if (x_pos)     port = PORT_E;
         else if (x_neg)     port = PORT_W;
      end else if ((MODE == RT_WF) && !esc) begin
         // West moves must come first, so any x- hop is deterministic.
         if (x_neg) begin
            port = PORT_W;
         end else if (x_pos && (y_pos || y_neg)) begin
            if (cred_e > cred_y)      port = PORT_E;
            else if (cred_y > cred_e) port = port_y;
            else begin
               tie  = 1'b1;
               port = rr ? port_y : PORT_E;
            end
         end else if (x_pos) begin
            port = PORT_E;
         end else if (y_pos || y_neg) begin
            port = port_y;
         end
      end else begin
         if (x_pos)               port = PORT_E;
         else if (x_neg)          port = PORT_W;
         else if (y_pos || y_neg) port = port_y;
      end
   end

endmodule

// File: rtl/rtcomp_param.sv
// ---------------------------------------------------------------------------
// rtcomp_param
// Per-packet route computation for one router input port. A header is
// captured in IDLE, routed in COMP from the captured fields and the credits
// seen that cycle, and the route is held locked in HOLD until the tail flit
// leaves the buffer.
//   clk, rst        : clock, synchronous active-high reset
//   xpos_i, ypos_i  : this router's coordinates (static)
//   hdr_valid_i/hdr_ready_o : header handshake
//   dstx_i, dsty_i, vch_i   : header destination and VC
//   cred_i          : free downstream credits, slice p belongs to port p
//   tail_i          : tail flit of the current packet has left the buffer
//   route_valid_o   : port_o / port_oh_o / vch_o valid and locked
//   port_o, port_oh_o : selected port as code and one-hot
//   vch_o           : output VC (captured header VC)
//   err_o           : one-cycle pulse, destination out of range
// ---------------------------------------------------------------------------
module rtcomp_param
   import noc_pkg::*;
#(
   parameter  int ARRAY_W    = 3,
   parameter  int XSIZE      = 8,
   parameter  int YSIZE      = 8,
   parameter  int VCH_N      = 2,
   parameter  int CRED_W     = 4,
   parameter  int ROUTE_MODE = 0,
   localparam int VCH_W      = (VCH_N > 1) ? $clog2(VCH_N) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ARRAY_W-1:0]  xpos_i,
   input  logic [ARRAY_W-1:0]  ypos_i,
   input  logic                hdr_valid_i,
   output logic                hdr_ready_o,
   input  logic [ARRAY_W-1:0]  dstx_i,
   input  logic [ARRAY_W-1:0]  dsty_i,
   input  logic [VCH_W-1:0]    vch_i,
   input  logic [5*CRED_W-1:0] cred_i,
   input  logic                tail_i,
   output logic                route_valid_o,
   output logic [2:0]          port_o,
   output logic [4:0]          port_oh_o,
   output logic [VCH_W-1:0]    vch_o,
   output logic                err_o
);

   rt_state_e          state;
   logic               rr_q;
   logic [ARRAY_W-1:0] dstx_p0, dsty_p0;
   logic [VCH_W-1:0]   vch_p0;

   port_e sel_port;
   logic  sel_err, sel_tie;

   rt_select #(
      .ARRAY_W    (ARRAY_W),
      .XSIZE      (XSIZE),
      .YSIZE      (YSIZE),
      .CRED_W     (CRED_W),
      .ROUTE_MODE (ROUTE_MODE)
   ) u_sel (
      .xpos (xpos_i),
      .ypos (ypos_i),
      .dstx (dstx_p0),
      .dsty (dsty_p0),
      .esc  (vch_p0 == '0),
      .cred (cred_i),
      .rr   (rr_q),
      .port (sel_port),
      .err  (sel_err),
      .tie  (sel_tie)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         hdr_ready_o   <= 1'b1;
         route_valid_o <= 1'b0;
         port_o        <= '0;
         port_oh_o     <= '0;
         vch_o         <= '0;
         err_o         <= 1'b0;
         rr_q          <= 1'b0;
      end else begin
         err_o <= 1'b0;
         case (state)
            // p0: capture header fields
            IDLE: begin
               if (hdr_valid_i && hdr_ready_o) begin
                  dstx_p0     <= dstx_i;
                  dsty_p0     <= dsty_i;
                  vch_p0      <= vch_i;
                  hdr_ready_o <= 1'b0;
                  state       <= COMP;
               end
            end
            // p1: register the selected route
            COMP: begin
               port_o        <= sel_port;
               port_oh_o     <= port2onehot(sel_port);
               vch_o         <= vch_p0;
               err_o         <= sel_err;
               route_valid_o <= 1'b1;
               if (sel_tie) rr_q <= ~rr_q;
               state         <= HOLD;
            end
            HOLD: begin
               if (tail_i) begin
                  route_valid_o <= 1'b0;
                  port_oh_o     <= '0;
                  hdr_ready_o   <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rtcomp_param.sv
// ---------------------------------------------------------------------------
// tb_rtcomp_param
// Four instances share one stimulus stream: XY, YX, west-first adaptive
// (all 8x8) and XY with XSIZE = 4. Expected routes come from a signed-delta
// reference model with its own tie-break pointer per instance.
// ---------------------------------------------------------------------------
module tb_rtcomp_param;

   logic        clk;
   logic        rst;
   logic [2:0]  xpos, ypos, dstx, dsty;
   logic        hdr_valid;
   logic [0:0]  vch;
   logic [19:0] cred;
   logic        tail;

   logic        rdy [4];
   logic        rv  [4];
   logic [2:0]  port[4];
   logic [4:0]  oh  [4];
   logic [0:0]  vcho[4];
   logic        err [4];

   int checks = 0;
   int errors = 0;
   int m_rr[4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      rtcomp_param #(
         .ARRAY_W    (3),
         .XSIZE      ((g == 3) ? 4 : 8),
         .YSIZE      (8),
         .VCH_N      (2),
         .CRED_W     (4),
         .ROUTE_MODE ((g == 1) ? 1 : (g == 2) ? 2 : 0)
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .xpos_i        (xpos),
         .ypos_i        (ypos),
         .hdr_valid_i   (hdr_valid),
         .hdr_ready_o   (rdy[g]),
         .dstx_i        (dstx),
         .dsty_i        (dsty),
         .vch_i         (vch),
         .cred_i        (cred),
         .tail_i        (tail),
         .route_valid_o (rv[g]),
         .port_o        (port[g]),
         .port_oh_o     (oh[g]),
         .vch_o         (vcho[g]),
         .err_o         (err[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int mode_of(input int i);
      return (i == 1) ? 1 : (i == 2) ? 2 : 0;
   endfunction

   function automatic int xs_of(input int i);
      return (i == 3) ? 4 : 8;
   endfunction

   function automatic logic [19:0] mk_cred(input int n, e, s, w, l);
      return {4'(l), 4'(w), 4'(s), 4'(e), 4'(n)};
   endfunction

   // Reference route: 0 = N, 1 = E, 2 = S, 3 = W, 4 = Local.
   function automatic int ref_route(input int mode, xs, ys, px, py, dx, dy,
                                    vc, input logic [19:0] cr, input int rr,
                                    output bit tie);
      int ddx, ddy, m, ce, cy, ydir;
      ddx  = dx - px;
      ddy  = dy - py;
      tie  = 0;
      m    = mode;
      ce   = int'(cr[7:4]);
      cy   = (ddy > 0) ? int'(cr[11:8]) : int'(cr[3:0]);
      ydir = (ddy > 0) ? 2 : 0;
      if (dx >= xs || dy >= ys) return 4;
      if (ddx == 0 && ddy == 0) return 4;
      if (m == 2 && vc == 0) m = 0;
      if (m == 0) begin
         if (ddx > 0) return 1;
         if (ddx < 0) return 3;
         return ydir;
      end
      if (m == 1) begin
         if (ddy != 0) return ydir;
         return (ddx > 0) ? 1 : 3;
      end
      if (ddx < 0) return 3;
      if (ddx == 0) return ydir;
      if (ddy == 0) return 1;
      if (ce > cy) return 1;
      if (cy > ce) return ydir;
      tie = 1;
      return (rr != 0) ? ydir : 1;
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_rr[i] = 0;
   endtask

   // One packet: header handshake, route check, 'hold' extra HOLD cycles,
   // then tail (or reset when rst_hold is set).
   task automatic send(input int px, py, dx, dy, vc, input logic [19:0] cr,
                       input int hold, input bit pre, input bit rst_hold,
                       output longint t_acc);
      int exp_p[4];
      bit exp_e[4];
      bit tie;
      @(negedge clk);
      xpos = 3'(px); ypos = 3'(py); dstx = 3'(dx); dsty = 3'(dy);
      vch = 1'(vc); cred = cr; hdr_valid = 1'b1; tail = 1'b0;
      for (int i = 0; i < 4; i++) chk($sformatf("rdy_idle%0d", i), int'(rdy[i]), 1);
      @(posedge clk);
      t_acc = $time;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rdy_comp%0d", i), int'(rdy[i]), 0);
         chk($sformatf("rv_comp%0d", i), int'(rv[i]), 0);
      end
      @(negedge clk);
      hdr_valid = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         exp_p[i] = ref_route(mode_of(i), xs_of(i), 8, px, py, dx, dy, vc, cr, m_rr[i], tie);
         if (tie) m_rr[i] = 1 - m_rr[i];
         exp_e[i] = (dx >= xs_of(i)) || (dy >= 8);
         chk($sformatf("rv%0d", i), int'(rv[i]), 1);
         chk($sformatf("port%0d", i), int'(port[i]), exp_p[i]);
         chk($sformatf("oh%0d", i), int'(oh[i]), 1 << exp_p[i]);
         chk($sformatf("vch%0d", i), int'(vcho[i]), vc);
         chk($sformatf("err%0d", i), int'(err[i]), int'(exp_e[i]));
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         cred = 20'($urandom);
         if (pre) begin
            hdr_valid = 1'b1;
            dstx = 3'($urandom); dsty = 3'($urandom); vch = 1'($urandom);
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("hold_rv%0d", i), int'(rv[i]), 1);
            chk($sformatf("hold_port%0d", i), int'(port[i]), exp_p[i]);
            chk($sformatf("hold_err%0d", i), int'(err[i]), 0);
            chk($sformatf("hold_rdy%0d", i), int'(rdy[i]), 0);
         end
      end
      @(negedge clk);
      cred = 20'($urandom);
      if (rst_hold) rst = 1'b1;
      else          tail = 1'b1;
      @(posedge clk);
      #1;
      tail = 1'b0;
      rst  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("end_rv%0d", i), int'(rv[i]), 0);
         chk($sformatf("end_oh%0d", i), int'(oh[i]), 0);
         chk($sformatf("end_rdy%0d", i), int'(rdy[i]), 1);
         chk($sformatf("end_err%0d", i), int'(err[i]), 0);
         if (rst_hold) begin
            chk($sformatf("rst_port%0d", i), int'(port[i]), 0);
            chk($sformatf("rst_vch%0d", i), int'(vcho[i]), 0);
            m_rr[i] = 0;
         end
      end
   endtask

   initial begin
      longint t0, t1;
      logic [19:0] cr;
      rst = 1'b1; hdr_valid = 1'b0; tail = 1'b0;
      xpos = '0; ypos = '0; dstx = '0; dsty = '0; vch = '0; cred = '0;
      for (int i = 0; i < 4; i++) m_rr[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst_rdy%0d", i), int'(rdy[i]), 1);
         chk($sformatf("rst_rv%0d", i), int'(rv[i]), 0);
         chk($sformatf("rst_port%0d", i), int'(port[i]), 0);
         chk($sformatf("rst_oh%0d", i), int'(oh[i]), 0);
         chk($sformatf("rst_vch%0d", i), int'(vcho[i]), 0);
         chk($sformatf("rst_err%0d", i), int'(err[i]), 0);
      end

      // XY / YX basics from router (2,2), tail two cycles into HOLD
      send(2, 2, 5, 1, 1, mk_cred(3, 3, 3, 3, 3), 2, 1'b0, 1'b0, t0);
      send(2, 2, 2, 2, 1, mk_cred(1, 2, 3, 4, 5), 0, 1'b0, 1'b0, t0);
      // Out-of-range x for the XSIZE = 4 instance
      send(2, 2, 6, 0, 1, mk_cred(1, 1, 1, 1, 1), 1, 1'b0, 1'b0, t0);

      // West-first adaptive from router (1,1)
      do_reset();
      send(1, 1, 3, 3, 1, mk_cred(0, 2, 7, 0, 0), 0, 1'b0, 1'b0, t0);
      send(1, 1, 3, 3, 1, mk_cred(0, 4, 4, 0, 0), 0, 1'b0, 1'b0, t0);
      send(1, 1, 3, 3, 1, mk_cred(0, 4, 4, 0, 0), 0, 1'b0, 1'b0, t0);
      send(1, 1, 3, 3, 0, mk_cred(0, 4, 4, 0, 0), 0, 1'b0, 1'b0, t0);
      send(4, 4, 6, 1, 1, mk_cred(9, 9, 1, 0, 0), 1, 1'b0, 1'b0, t0);

      // Next header presented during HOLD, then single-flit spacing
      send(3, 3, 0, 5, 1, mk_cred(2, 2, 2, 2, 2), 2, 1'b1, 1'b0, t0);
      send(3, 3, 7, 7, 1, mk_cred(2, 2, 2, 2, 2), 0, 1'b0, 1'b0, t0);
      send(3, 3, 5, 0, 1, mk_cred(2, 5, 2, 2, 2), 0, 1'b0, 1'b0, t1);
      chk("spacing", int'((t1 - t0) / 10), 3);

      // Reset in HOLD, then a tie must pick E again
      send(1, 1, 3, 3, 1, mk_cred(0, 4, 4, 0, 0), 0, 1'b0, 1'b0, t0);
      send(1, 1, 3, 3, 1, mk_cred(0, 4, 4, 0, 0), 1, 1'b0, 1'b1, t0);
      send(1, 1, 3, 3, 1, mk_cred(0, 4, 4, 0, 0), 0, 1'b0, 1'b0, t0);

      // Random traffic; small credit values make ties common
      for (int n = 0; n < 200; n++) begin
         for (int k = 0; k < 5; k++) cr[k*4 +: 4] = 4'($urandom_range(0, 3));
         send(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 1)), cr, int'($urandom_range(0, 3)),
              1'($urandom), ($urandom_range(0, 19) == 0), t0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
